// File: rtl/sha3_block_packer_pkg.sv
// Shared definitions for the SHA-3 block packer: mode encodings, per-mode rates,
// the rate lookup helpers and the packer FSM state type.
package sha3_block_packer_pkg;

  typedef enum logic [1:0] {
    MODE_SHA3_256 = 2'd0,
    MODE_SHA3_512 = 2'd1,
    MODE_SHAKE128 = 2'd2,
    MODE_SHAKE256 = 2'd3
  } mode_e;

  localparam logic [10:0] RATE_BITS_SHA3_256 = 11'd1088;
  localparam logic [10:0] RATE_BITS_SHA3_512 = 11'd576;
  localparam logic [10:0] RATE_BITS_SHAKE128 = 11'd1344;
  localparam logic [10:0] RATE_BITS_SHAKE256 = 11'd1088;

  localparam logic [7:0] RATE_BYTES_SHA3_256 = 8'd136;
  localparam logic [7:0] RATE_BYTES_SHA3_512 = 8'd72;
  localparam logic [7:0] RATE_BYTES_SHAKE128 = 8'd168;
  localparam logic [7:0] RATE_BYTES_SHAKE256 = 8'd136;

  localparam int MAX_RATE_BITS = 1344;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_e;

  function automatic logic [10:0] rateBits(input logic [1:0] mode);
    logic [10:0] r;
    case (mode)
      MODE_SHA3_512: r = RATE_BITS_SHA3_512;
      MODE_SHAKE128: r = RATE_BITS_SHAKE128;
      MODE_SHAKE256: r = RATE_BITS_SHAKE256;
      default:       r = RATE_BITS_SHA3_256;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] rateBytes(input logic [1:0] mode);
    logic [7:0] r;
    case (mode)
      MODE_SHA3_512: r = RATE_BYTES_SHA3_512;
      MODE_SHAKE128: r = RATE_BYTES_SHAKE128;
      MODE_SHAKE256: r = RATE_BYTES_SHAKE256;
      default:       r = RATE_BYTES_SHA3_256;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sha3_block_packer_if.sv
// Bundle of the packer's control, word-stream and block-output signals.
// The slave side is the packer itself; the master side is whoever feeds and drains it.
interface sha3_block_packer_if
  import sha3_block_packer_pkg::*;
#(
  parameter int WORD_W = 64
);

  logic                     start;
  logic [1:0]               mode_in;
  logic [12:0]              out_len_in;
  logic                     s_valid;
  logic                     s_ready;
  logic [WORD_W-1:0]        s_data;
  logic [3:0]               s_bytes;
  logic                     s_last;
  logic                     blk_valid;
  logic                     blk_ready;
  logic [MAX_RATE_BITS-1:0] data_in;
  logic [10:0]              data_len;
  logic [12:0]              length;
  logic                     in_finish;
  logic [1:0]               mode_out;
  logic [10:0]              rate_out;
  logic                     busy;

  modport slave (
    input  start, mode_in, out_len_in, s_valid, s_data, s_bytes, s_last, blk_ready,
    output s_ready, blk_valid, data_in, data_len, length, in_finish, mode_out, rate_out, busy
  );

  modport master (
    output start, mode_in, out_len_in, s_valid, s_data, s_bytes, s_last, blk_ready,
    input  s_ready, blk_valid, data_in, data_len, length, in_finish, mode_out, rate_out, busy
  );

endinterface

// File: rtl/sha3_block_packer.sv
// Packs a little-endian byte stream of 64-bit words into rate-sized, MSB-first
// blocks for a Keccak controller, flagging the final block of each message.
module sha3_block_packer
  import sha3_block_packer_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input logic               clk,
  input logic               rst,
  sha3_block_packer_if.slave bus
);

  localparam int WORD_BYTES = WORD_W / 8;

  state_e                   state_q;
  logic [7:0]               cnt_q;
  logic [7:0]               cnt_d;
  logic                     pendEmpty_q;
  logic                     sReady_q;
  logic                     blkValid_q;
  logic                     busy_q;
  logic [MAX_RATE_BITS-1:0] dataIn_q;
  logic [10:0]              dataLen_q;
  logic                     inFinish_q;
  logic [12:0]              length_q;
  logic [1:0]               mode_q;
  logic                     accept;
  logic [WORD_W-1:0]        laneWord;
  logic [MAX_RATE_BITS-1:0] placed;

  // Reverse the word's valid bytes to MSB-first order, then slide them down to byte offset cnt.
  always_comb begin
    accept   = bus.s_valid && sReady_q;
    cnt_d    = cnt_q + {4'd0, bus.s_bytes};
    laneWord = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (k < int'(bus.s_bytes)) begin
        laneWord[WORD_W-1-8*k -: 8] = bus.s_data[8*k +: 8];
      end
    end
    placed = {laneWord, {(MAX_RATE_BITS-WORD_W){1'b0}}} >> {cnt_q, 3'b000};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pendEmpty_q <= 1'b0;
      sReady_q    <= 1'b0;
      blkValid_q  <= 1'b0;
      busy_q      <= 1'b0;
      dataIn_q    <= '0;
      dataLen_q   <= '0;
      inFinish_q  <= 1'b0;
      length_q    <= '0;
      mode_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mode_q      <= bus.mode_in;
            length_q    <= bus.out_len_in;
            cnt_q       <= '0;
            dataIn_q    <= '0;
            dataLen_q   <= '0;
            inFinish_q  <= 1'b0;
            pendEmpty_q <= 1'b0;
            sReady_q    <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            dataIn_q <= dataIn_q | placed;
            cnt_q    <= cnt_d;
            // A last word that exactly fills the block still owes an empty final block.
            if (cnt_d == rateBytes(mode_q)) begin
              sReady_q    <= 1'b0;
              blkValid_q  <= 1'b1;
              dataLen_q   <= {cnt_d, 3'b000};
              inFinish_q  <= 1'b0;
              pendEmpty_q <= bus.s_last;
              state_q     <= EMIT;
            end else if (bus.s_last) begin
              sReady_q   <= 1'b0;
              blkValid_q <= 1'b1;
              dataLen_q  <= {cnt_d, 3'b000};
              inFinish_q <= 1'b1;
              state_q    <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.blk_ready) begin
            if (inFinish_q) begin
              blkValid_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              dataIn_q <= '0;
              cnt_q    <= '0;
              if (pendEmpty_q) begin
                pendEmpty_q <= 1'b0;
                inFinish_q  <= 1'b1;
                dataLen_q   <= '0;
              end else begin
                blkValid_q <= 1'b0;
                sReady_q   <= 1'b1;
                state_q    <= FILL;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s_ready   = sReady_q;
  assign bus.blk_valid = blkValid_q;
  assign bus.busy      = busy_q;
  assign bus.data_in   = dataIn_q;
  assign bus.data_len  = dataLen_q;
  assign bus.in_finish = inFinish_q;
  assign bus.length    = length_q;
  assign bus.mode_out  = mode_q;
  assign bus.rate_out  = rateBits(mode_q);

endmodule

// File: tb/tb_sha3_block_packer.sv
// Directed bench for sha3_block_packer: short, exact-rate, multi-block and empty
// messages, a stalled downstream, and reset in the middle of a message.
module tb_sha3_block_packer;
  import sha3_block_packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  sha3_block_packer_if bus ();

  sha3_block_packer #(.WORD_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  // Word whose byte k carries the value base+k.
  function automatic logic [63:0] patWord(input int base);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(base + k);
    return w;
  endfunction

  // Block holding count bytes base, base+1, ... from offset 0, MSB-first.
  function automatic logic [1343:0] patBlock(input int base, input int count);
    logic [1343:0] b;
    b = '0;
    for (int j = 0; j < count; j++) b[1343-8*j -: 8] = 8'(base + j);
    return b;
  endfunction

  function automatic int firstDiffByte(input logic [1343:0] a, input logic [1343:0] b);
    for (int j = 0; j < 168; j++) if (a[1343-8*j -: 8] !== b[1343-8*j -: 8]) return j;
    return 0;
  endfunction

  function automatic logic [7:0] byteAt(input logic [1343:0] v, input int j);
    return v[1343-8*j -: 8];
  endfunction

  task automatic startMsg(input logic [1:0] mode, input logic [12:0] len);
    bus.start      = 1'b1;
    bus.mode_in    = mode;
    bus.out_len_in = len;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic sendWord(input logic [63:0] d, input logic [3:0] nb, input logic l);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_bytes = nb;
    bus.s_last  = l;
    while (!bus.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (t >= 50) begin
      miscompares++;
      $display("[TB] FAIL word_accept_timeout s_ready got %b want 1", bus.s_ready);
    end
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic acceptBlk();
    bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.mode_in = '0; bus.out_len_in = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_bytes = '0; bus.s_last = 1'b0;
    bus.blk_ready = 1'b0;
    #12;
    vectors++;
    if ({bus.s_ready, bus.blk_valid, bus.busy, bus.in_finish} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_flags got %b want 0000", {bus.s_ready, bus.blk_valid, bus.busy, bus.in_finish});
    end
    vectors++;
    if (bus.data_in !== '0 || bus.data_len !== 11'd0 || bus.length !== 13'd0 || bus.mode_out !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs got len=%0d length=%0d mode=%0d want 0,0,0", bus.data_len, bus.length, bus.mode_out);
    end
    vectors++;
    if (bus.rate_out !== 11'd1088) begin
      miscompares++;
      $display("[TB] FAIL reset_rate got %0d want 1088", bus.rate_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_flags got s_ready=%b busy=%b want 0,0", bus.s_ready, bus.busy);
    end
  endtask

  task automatic test_short_msg();
    logic [1343:0] exp;
    int d;
    exp = {24'h616263, 1320'd0};
    startMsg(2'd0, 13'd256);
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL fill_flags got s_ready=%b busy=%b want 1,1", bus.s_ready, bus.busy);
    end
    sendWord(64'h0000_0000_0063_6261, 4'd3, 1'b1);
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL short_latency got blk_valid=%b s_ready=%b want 1,0", bus.blk_valid, bus.s_ready);
    end
    vectors++;
    if (bus.data_in !== exp) begin
      miscompares++;
      d = firstDiffByte(bus.data_in, exp);
      $display("[TB] FAIL short_data byte %0d got %h want %h", d, byteAt(bus.data_in, d), byteAt(exp, d));
    end
    vectors++;
    if (bus.data_len !== 11'd24 || bus.in_finish !== 1'b1 || bus.length !== 13'd256) begin
      miscompares++;
      $display("[TB] FAIL short_meta got len=%0d fin=%b length=%0d want 24,1,256", bus.data_len, bus.in_finish, bus.length);
    end
    acceptBlk();
    vectors++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL short_done got blk_valid=%b busy=%b want 0,0", bus.blk_valid, bus.busy);
    end
  endtask

  task automatic test_exact_rate();
    logic [1343:0] exp;
    int d;
    exp = patBlock(0, 72);
    startMsg(2'd1, 13'd512);
    for (int i = 0; i < 9; i++) sendWord(patWord(8 * i), 4'd8, (i == 8));
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd576 || bus.in_finish !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rate_blk1 got valid=%b len=%0d fin=%b want 1,576,0", bus.blk_valid, bus.data_len, bus.in_finish);
    end
    vectors++;
    if (bus.data_in !== exp) begin
      miscompares++;
      d = firstDiffByte(bus.data_in, exp);
      $display("[TB] FAIL rate_data byte %0d got %h want %h", d, byteAt(bus.data_in, d), byteAt(exp, d));
    end
    vectors++;
    if (bus.rate_out !== 11'd576 || bus.mode_out !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL rate_mode got rate=%0d mode=%0d want 576,1", bus.rate_out, bus.mode_out);
    end
    acceptBlk();
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd0 || bus.in_finish !== 1'b1 || bus.data_in !== '0) begin
      miscompares++;
      $display("[TB] FAIL rate_blk2 got valid=%b len=%0d fin=%b want 1,0,1 with zero data", bus.blk_valid, bus.data_len, bus.in_finish);
    end
    acceptBlk();
    vectors++;
    if (bus.blk_valid !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rate_done got blk_valid=%b busy=%b want 0,0", bus.blk_valid, bus.busy);
    end
  endtask

  task automatic test_multi_block();
    logic [1343:0] exp;
    int d;
    startMsg(2'd2, 13'd1234);
    for (int i = 0; i < 21; i++) sendWord(patWord(8 * i), 4'd8, 1'b0);
    exp = patBlock(0, 168);
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd1344 || bus.in_finish !== 1'b0 || bus.length !== 13'd1234) begin
      miscompares++;
      $display("[TB] FAIL multi_blk1 got valid=%b len=%0d fin=%b length=%0d want 1,1344,0,1234", bus.blk_valid, bus.data_len, bus.in_finish, bus.length);
    end
    vectors++;
    if (bus.data_in !== exp) begin
      miscompares++;
      d = firstDiffByte(bus.data_in, exp);
      $display("[TB] FAIL multi_data1 byte %0d got %h want %h", d, byteAt(bus.data_in, d), byteAt(exp, d));
    end
    acceptBlk();
    vectors++;
    if (bus.s_ready !== 1'b1 || bus.blk_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL multi_refill got s_ready=%b blk_valid=%b want 1,0", bus.s_ready, bus.blk_valid);
    end
    for (int i = 21; i < 25; i++) sendWord(patWord(8 * i), 4'd8, (i == 24));
    exp = patBlock(168, 32);
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd256 || bus.in_finish !== 1'b1 || bus.length !== 13'd1234) begin
      miscompares++;
      $display("[TB] FAIL multi_blk2 got valid=%b len=%0d fin=%b length=%0d want 1,256,1,1234", bus.blk_valid, bus.data_len, bus.in_finish, bus.length);
    end
    vectors++;
    if (bus.data_in !== exp) begin
      miscompares++;
      d = firstDiffByte(bus.data_in, exp);
      $display("[TB] FAIL multi_data2 byte %0d got %h want %h", d, byteAt(bus.data_in, d), byteAt(exp, d));
    end
    vectors++;
    if (bus.rate_out !== 11'd1344 || bus.mode_out !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL multi_mode got rate=%0d mode=%0d want 1344,2", bus.rate_out, bus.mode_out);
    end
    acceptBlk();
  endtask

  task automatic test_empty();
    startMsg(2'd3, 13'd4096);
    sendWord(64'hDEAD_BEEF_0123_4567, 4'd0, 1'b1);
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd0 || bus.in_finish !== 1'b1 || bus.data_in !== '0) begin
      miscompares++;
      $display("[TB] FAIL empty_blk got valid=%b len=%0d fin=%b want 1,0,1 with zero data", bus.blk_valid, bus.data_len, bus.in_finish);
    end
    vectors++;
    if (bus.rate_out !== 11'd1088 || bus.mode_out !== 2'd3) begin
      miscompares++;
      $display("[TB] FAIL empty_mode got rate=%0d mode=%0d want 1088,3", bus.rate_out, bus.mode_out);
    end
    acceptBlk();
    vectors++;
    if (bus.busy !== 1'b0 || bus.blk_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty_done got busy=%b blk_valid=%b want 0,0", bus.busy, bus.blk_valid);
    end
  endtask

  task automatic test_stall();
    logic [1343:0] exp;
    int d;
    exp = patBlock(16, 11);
    startMsg(2'd0, 13'd100);
    sendWord(patWord(16), 4'd8, 1'b0);
    sendWord(patWord(24), 4'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        bus.start      = 1'b1;
        bus.mode_in    = 2'd1;
        bus.out_len_in = 13'd999;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = 64'hA5A5_A5A5_A5A5_A5A5;
      bus.s_bytes = 4'd8;
      bus.s_last  = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      vectors++;
      if (bus.blk_valid !== 1'b1 || bus.s_ready !== 1'b0 || bus.data_len !== 11'd88 || bus.in_finish !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL stall_ctl cycle %0d got valid=%b s_ready=%b len=%0d fin=%b want 1,0,88,1", c, bus.blk_valid, bus.s_ready, bus.data_len, bus.in_finish);
      end
      vectors++;
      if (bus.data_in !== exp || bus.mode_out !== 2'd0 || bus.length !== 13'd100) begin
        miscompares++;
        d = firstDiffByte(bus.data_in, exp);
        $display("[TB] FAIL stall_hold cycle %0d byte %0d got %h want %h mode=%0d length=%0d", c, d, byteAt(bus.data_in, d), byteAt(exp, d), bus.mode_out, bus.length);
      end
    end
    bus.s_valid = 1'b0;
    acceptBlk();
    vectors++;
    if (bus.busy !== 1'b0 || bus.mode_out !== 2'd0 || bus.length !== 13'd100 || bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_ignored_start got busy=%b mode=%0d length=%0d s_ready=%b want 0,0,100,0", bus.busy, bus.mode_out, bus.length, bus.s_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [1343:0] exp;
    int d;
    exp = {16'hABCD, 1328'd0};
    startMsg(2'd3, 13'd777);
    for (int i = 0; i < 4; i++) sendWord(64'hFFFF_FFFF_FFFF_FFFF, 4'd8, 1'b0);
    rst = 1'b1;
    #2;
    vectors++;
    if ({bus.s_ready, bus.blk_valid, bus.busy} !== 3'b000 || bus.data_in !== '0 || bus.mode_out !== 2'd0 || bus.length !== 13'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got flags=%b mode=%0d length=%0d want 000,0,0", {bus.s_ready, bus.blk_valid, bus.busy}, bus.mode_out, bus.length);
    end
    vectors++;
    if (bus.rate_out !== 11'd1088) begin
      miscompares++;
      $display("[TB] FAIL midreset_rate got %0d want 1088", bus.rate_out);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.blk_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL midreset_no_blk cycle %0d got %b want 0", c, bus.blk_valid);
      end
    end
    startMsg(2'd0, 13'd256);
    sendWord(64'h0000_0000_0000_CDAB, 4'd2, 1'b1);
    vectors++;
    if (bus.data_in !== exp) begin
      miscompares++;
      d = firstDiffByte(bus.data_in, exp);
      $display("[TB] FAIL midreset_data byte %0d got %h want %h", d, byteAt(bus.data_in, d), byteAt(exp, d));
    end
    vectors++;
    if (bus.blk_valid !== 1'b1 || bus.data_len !== 11'd16 || bus.in_finish !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset_meta got valid=%b len=%0d fin=%b want 1,16,1", bus.blk_valid, bus.data_len, bus.in_finish);
    end
    acceptBlk();
  endtask

  initial begin
    test_reset();
    test_short_msg();
    test_exact_rate();
    test_multi_block();
    test_empty();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
